// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default timing
// constants and frame geometry.
package uart_pkg;

    localparam int DEFAULT_BIT_COUNTS  = 10420;
    localparam int DEFAULT_HALF_COUNTS = DEFAULT_BIT_COUNTS / 2;
    localparam int FRAME_DATA_BITS     = 8;
    localparam int BIT_IDX_W           = $clog2(FRAME_DATA_BITS);

    typedef logic [BIT_IDX_W-1:0]       bit_idx_t;
    typedef logic [FRAME_DATA_BITS-1:0] frame_data_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity(input frame_data_t data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Down-counting bit timer. A load of N makes expired_o rise exactly N cycles
// later, so reloading on the expiry cycle keeps a seamless N-cycle period.
module uart_rx_bit_timer #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (load_val_i == '0) ? '0 : load_val_i - WIDTH'(1);
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit. Samples
// each bit at its mid-point using a half-bit offset from the start edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_COUNTS  = DEFAULT_BIT_COUNTS,
    parameter int HALF_COUNTS = BIT_COUNTS / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    output logic [FRAME_DATA_BITS-1:0] rx_data,
    output logic                       rx_valid,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       busy
);

    localparam int TIMER_W = $clog2(BIT_COUNTS + 1);

    rx_state_e   state_q, state_d;

    logic        rx_meta_q;
    logic        rx_s_q;
    logic        rx_prev_q;
    logic        rx_fall;

    bit_idx_t    bit_idx_q;
    frame_data_t shift_q;
    logic        parity_bit_q;
    frame_data_t rx_data_q;
    logic        rx_valid_q;
    logic        parity_err_q;
    logic        frame_err_q;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expired;
    logic               data_begin;
    logic               shift_en;
    logic               parity_en;
    logic               commit;

    // Synchronizer and edge detector idle high so release from reset on an
    // idle line never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    uart_rx_bit_timer #(
        .WIDTH (TIMER_W)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expired_o  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall) state_d = ST_START;
            end
            ST_START: begin
                if (timer_expired) state_d = rx_s_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (timer_expired && bit_idx_q == bit_idx_t'(FRAME_DATA_BITS - 1)) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (timer_expired) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (timer_expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_load = 1'b0;
        timer_val  = TIMER_W'(BIT_COUNTS);
        data_begin = 1'b0;
        shift_en   = 1'b0;
        parity_en  = 1'b0;
        commit     = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                timer_load = rx_fall;
                timer_val  = TIMER_W'(HALF_COUNTS);
            end
            ST_START: begin
                data_begin = timer_expired & ~rx_s_q;
                timer_load = data_begin;
            end
            ST_DATA: begin
                shift_en   = timer_expired;
                timer_load = timer_expired;
            end
            ST_PARITY: begin
                parity_en  = timer_expired;
                timer_load = timer_expired;
            end
            ST_STOP: begin
                commit = timer_expired;
            end
            default: ;
        endcase
    end

    // NOTE: the shift register is reset along with the control state so a
    // mid-frame reset leaves no stale bits behind; it is only eight flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_q    <= '0;
            shift_q      <= '0;
            parity_bit_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= commit;
            if (data_begin) begin
                bit_idx_q <= '0;
            end
            if (shift_en) begin
                shift_q[bit_idx_q] <= rx_s_q;
                bit_idx_q          <= bit_idx_q + bit_idx_t'(1);
            end
            if (parity_en) begin
                parity_bit_q <= rx_s_q;
            end
            if (commit) begin
                rx_data_q    <= shift_q;
                parity_err_q <= parity_bit_q ^ even_parity(shift_q);
                frame_err_q  <= ~rx_s_q;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
